// File: rtl/resampler_cfg_ctrl_if.sv
// Configuration, stream-gating and resampler-control bundle
// for the resampler configuration sequencer.
interface resampler_cfg_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  en_i;
  logic                  cfg_valid_i;
  logic                  cfg_ready_o;
  logic [DATA_WIDTH-1:0] cfg_interp_i;
  logic [DATA_WIDTH-1:0] cfg_dec_i;
  logic [2:0]            cfg_round_i;
  logic                  cfg_err_o;
  logic                  cfg_done_o;
  logic                  busy_o;
  logic                  s_tvalid_i;
  logic                  s_tready_o;
  logic                  m_tvalid_o;
  logic                  m_tready_i;
  logic                  en_o;
  logic                  flush_o;
  logic [DATA_WIDTH-1:0] interpolation_o;
  logic [DATA_WIDTH-1:0] decimation_o;
  logic [2:0]            round_type_o;

  modport slave (
    input  en_i, cfg_valid_i, cfg_interp_i,
    input  cfg_dec_i, cfg_round_i,
    input  s_tvalid_i, m_tready_i,
    output cfg_ready_o, cfg_err_o, cfg_done_o,
    output busy_o, s_tready_o, m_tvalid_o,
    output en_o, flush_o, interpolation_o,
    output decimation_o, round_type_o
  );

  modport master (
    output en_i, cfg_valid_i, cfg_interp_i,
    output cfg_dec_i, cfg_round_i,
    output s_tvalid_i, m_tready_i,
    input  cfg_ready_o, cfg_err_o, cfg_done_o,
    input  busy_o, s_tready_o, m_tvalid_o,
    input  en_o, flush_o, interpolation_o,
    input  decimation_o, round_type_o
  );
endinterface

// File: rtl/resampler_cfg_ctrl.sv
// Run-time configuration sequencer: gate stream, drain,
// flush, then apply new resampler ratios atomically.
module resampler_cfg_ctrl #(
  parameter int              DATA_WIDTH   = 16,
  parameter int              DRAIN_CYCLES = 40,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              DEF_INTERP   = 1,
  parameter int              DEF_DEC      = 1,
  parameter logic [2:0]      DEF_ROUND    = 3'b010
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  resampler_cfg_ctrl_if.slave  bus
);
  localparam int RATIO_MAX = 2 ** $clog2(DATA_WIDTH);
  localparam int CW =
    $clog2(DRAIN_CYCLES + FLUSH_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] RMAX =
    DATA_WIDTH'(RATIO_MAX);
  localparam logic [DATA_WIDTH-1:0] D_INT =
    DATA_WIDTH'(DEF_INTERP);
  localparam logic [DATA_WIDTH-1:0] D_DEC =
    DATA_WIDTH'(DEF_DEC);
  localparam logic [CW-1:0] DRAIN_LAST =
    CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] FLUSH_LAST =
    CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN, ST_DRAIN, ST_FLUSH, ST_APPLY
  } state_t;

  state_t                r_state, w_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_sh_int, r_sh_dec;
  logic [2:0]            r_sh_rnd;
  logic [DATA_WIDTH-1:0] r_int, r_dec;
  logic [2:0]            r_rnd;
  logic                  r_flush, r_err, r_done;
  logic                  w_ready, w_busy, w_en;
  logic                  w_mvalid, w_sready;
  logic                  w_accept, w_legal;

  assign w_legal =
    (bus.cfg_interp_i != '0) &&
    (bus.cfg_interp_i <= RMAX) &&
    (bus.cfg_dec_i != '0) &&
    (bus.cfg_dec_i <= RMAX) &&
    $onehot(bus.cfg_round_i);
  assign w_accept = w_ready & bus.cfg_valid_i;

  // Next state, counter and combinational gating
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_ready   = 1'b0;
    w_busy    = 1'b1;
    w_en      = bus.en_i;
    w_mvalid  = 1'b0;
    w_sready  = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        w_busy   = 1'b0;
        w_ready  = bus.en_i;
        w_mvalid = bus.s_tvalid_i;
        w_sready = bus.m_tready_i;
        if (w_accept && w_legal) begin
          w_nxt     = ST_DRAIN;
          w_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        if (bus.en_i) begin
          if (r_cnt == DRAIN_LAST) begin
            w_nxt     = ST_FLUSH;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_FLUSH: begin
        w_en = 1'b0;
        if (bus.en_i) begin
          if (r_cnt == FLUSH_LAST) begin
            w_nxt     = ST_APPLY;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_APPLY: begin
        if (bus.en_i) w_nxt = ST_RUN;
      end
      default: w_nxt = ST_RUN;
    endcase
  end

  // State and counter registers, frozen while en_i is low
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else if (bus.en_i) begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Shadow capture of a legal accepted request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sh_int <= D_INT;
      r_sh_dec <= D_DEC;
      r_sh_rnd <= DEF_ROUND;
    end else if (w_accept && w_legal) begin
      r_sh_int <= bus.cfg_interp_i;
      r_sh_dec <= bus.cfg_dec_i;
      r_sh_rnd <= bus.cfg_round_i;
    end
  end

  // Live ratio outputs only change leaving APPLY
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_int <= D_INT;
      r_dec <= D_DEC;
      r_rnd <= DEF_ROUND;
    end else if (r_state == ST_APPLY && bus.en_i) begin
      r_int <= r_sh_int;
      r_dec <= r_sh_dec;
      r_rnd <= r_sh_rnd;
    end
  end

  // Flush level tracks FLUSH state; status pulses last one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flush <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (bus.en_i) r_flush <= (w_nxt == ST_FLUSH);
      r_err  <= w_accept & ~w_legal;
      r_done <= (r_state == ST_APPLY) & bus.en_i;
    end
  end

  assign bus.cfg_ready_o     = w_ready;
  assign bus.busy_o          = w_busy;
  assign bus.en_o            = w_en;
  assign bus.m_tvalid_o      = w_mvalid;
  assign bus.s_tready_o      = w_sready;
  assign bus.flush_o         = r_flush;
  assign bus.cfg_err_o       = r_err;
  assign bus.cfg_done_o      = r_done;
  assign bus.interpolation_o = r_int;
  assign bus.decimation_o    = r_dec;
  assign bus.round_type_o    = r_rnd;
endmodule

// File: tb/tb_resampler_cfg_ctrl.sv
// Randomized bench for resampler_cfg_ctrl against a
// remaining-gated-cycles reference model.
module tb_resampler_cfg_ctrl;
  localparam int DW    = 16;
  localparam int DRAIN = 40;
  localparam int FLUSH = 2;
  localparam int RMAX  = 16;
  localparam int SEQ   = DRAIN + FLUSH + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  resampler_cfg_ctrl_if #(.DATA_WIDTH(DW)) u_if();

  resampler_cfg_ctrl #(
    .DATA_WIDTH  (DW),
    .DRAIN_CYCLES(DRAIN),
    .FLUSH_CYCLES(FLUSH),
    .DEF_INTERP  (1),
    .DEF_DEC     (1),
    .DEF_ROUND   (3'b010)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (u_if.slave)
  );

  int total = 0;
  int bad   = 0;

  // model: enabled gated cycles left, live and pending cfg
  int          m_rem;
  logic [15:0] m_int, m_dec, p_int, p_dec;
  logic [2:0]  m_rnd, p_rnd;
  logic        m_err, m_done;
  bit          did_frst;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal(input int a, input int b,
                               input logic [2:0] r);
    return a >= 1 && a <= RMAX && b >= 1 && b <= RMAX &&
           (r == 3'b001 || r == 3'b010 || r == 3'b100);
  endfunction

  task automatic model_reset();
    m_rem  = 0;
    m_int  = 16'd1;
    m_dec  = 16'd1;
    m_rnd  = 3'b010;
    m_err  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic check_outputs();
    bit busy, fl, en;
    busy = (m_rem > 0);
    fl   = (m_rem > 1) && (m_rem <= FLUSH + 1);
    en   = u_if.en_i;
    chk("busy",   u_if.busy_o,      busy);
    chk("ready",  u_if.cfg_ready_o, !busy && en);
    chk("mvalid", u_if.m_tvalid_o,
        busy ? 1'b0 : u_if.s_tvalid_i);
    chk("sready", u_if.s_tready_o,
        busy ? 1'b0 : u_if.m_tready_i);
    chk("en_o",   u_if.en_o,        fl ? 1'b0 : en);
    chk("flush",  u_if.flush_o,     fl);
    chk("err",    u_if.cfg_err_o,   m_err);
    chk("done",   u_if.cfg_done_o,  m_done);
    chk("interp", u_if.interpolation_o, m_int);
    chk("dec",    u_if.decimation_o,    m_dec);
    chk("round",  u_if.round_type_o,    m_rnd);
  endtask

  task automatic model_step();
    logic n_err, n_done;
    if (rst) begin
      model_reset();
      return;
    end
    n_err  = 1'b0;
    n_done = 1'b0;
    if (u_if.en_i) begin
      if (m_rem == 0) begin
        if (u_if.cfg_valid_i) begin
          if (legal(int'(u_if.cfg_interp_i),
                    int'(u_if.cfg_dec_i),
                    u_if.cfg_round_i)) begin
            p_int = u_if.cfg_interp_i;
            p_dec = u_if.cfg_dec_i;
            p_rnd = u_if.cfg_round_i;
            m_rem = SEQ;
          end else begin
            n_err = 1'b1;
          end
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_int  = p_int;
          m_dec  = p_dec;
          m_rnd  = p_rnd;
          n_done = 1'b1;
        end
      end
    end
    m_err  = n_err;
    m_done = n_done;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst               = 1'b1;
    did_frst          = 1'b0;
    u_if.en_i         = 1'b0;
    u_if.cfg_valid_i  = 1'b0;
    u_if.cfg_interp_i = '0;
    u_if.cfg_dec_i    = '0;
    u_if.cfg_round_i  = '0;
    u_if.s_tvalid_i   = 1'b0;
    u_if.m_tready_i   = 1'b0;
    p_int = 16'd1;
    p_dec = 16'd1;
    p_rnd = 3'b010;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst             = 1'b0;
    u_if.en_i       = 1'b1;
    u_if.s_tvalid_i = 1'b1;
    u_if.m_tready_i = 1'b1;
    cycle();
    // directed: legal cfg 4/2/to-zero
    u_if.cfg_valid_i  = 1'b1;
    u_if.cfg_interp_i = 16'd4;
    u_if.cfg_dec_i    = 16'd2;
    u_if.cfg_round_i  = 3'b001;
    cycle();
    u_if.cfg_valid_i = 1'b0;
    repeat (SEQ + 2) cycle();
    chk("interp_4", u_if.interpolation_o, 32'd4);
    // directed illegal requests
    u_if.cfg_valid_i = 1'b1;
    u_if.cfg_interp_i = 16'd0;
    cycle();
    u_if.cfg_interp_i = 16'd2;
    u_if.cfg_dec_i    = 16'd17;
    cycle();
    u_if.cfg_dec_i   = 16'd2;
    u_if.cfg_round_i = 3'b011;
    cycle();
    u_if.cfg_valid_i = 1'b0;
    cycle();
    for (int i = 0; i < 4000; i++) begin
      u_if.en_i = ($urandom_range(0, 9) != 0);
      u_if.cfg_valid_i = ($urandom_range(0, 19) == 0);
      u_if.cfg_interp_i = 16'($urandom_range(0, 18));
      u_if.cfg_dec_i    = 16'($urandom_range(0, 18));
      u_if.cfg_round_i  = 3'($urandom_range(0, 7));
      u_if.s_tvalid_i   = 1'($urandom_range(0, 1));
      u_if.m_tready_i   = 1'($urandom_range(0, 1));
      if (!did_frst && m_rem == FLUSH + 1) begin
        rst      = 1'b1;
        did_frst = 1'b1;
      end else begin
        rst = ($urandom_range(0, 499) == 0);
      end
      if (rst) model_reset();
      cycle();
    end
    rst = 1'b0;
    chk("flush_rst_seen", {31'd0, did_frst}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
